// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths,
// address/data types and the hard-wired zero register index.
package regfile_pkg;

    localparam int RF_DW   = 32;
    localparam int RF_NREG = 32;
    localparam int RF_AW   = $clog2(RF_NREG);

    typedef logic [RF_AW-1:0] reg_addr_t;
    typedef logic [RF_DW-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = {RF_AW{1'b0}};

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register tracking
// issued-but-not-written-back destinations, busy flags for the read ports
// and sticky overflow/underflow error flags.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NR   = 4,
    parameter int NW   = 2,
    parameter int CW   = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    re,
    input  logic [NR*AW-1:0] raddr,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW-1:0]    alloc,
    input  logic [NW*AW-1:0] alloc_addr,
    input  logic             flush,
    output logic [NR-1:0]    rbusy,
    output logic             err_ovf,
    output logic             err_unf
);

    // Wide enough for a full counter plus every port hitting one register.
    localparam int            SW      = CW + NW + 1;
    localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0] CNT_MAX = {{(NW+1){1'b0}}, {CW{1'b1}}};

    logic [CW-1:0] cnt_r     [NREG];
    logic [CW-1:0] cnt_nxt_s [NREG];
    logic [SW-1:0] acnt_s    [NREG];
    logic [SW-1:0] wcnt_s    [NREG];
    logic [SW-1:0] sum_s;
    logic [SW-1:0] diff_s;
    logic [NR-1:0] rbusy_s;
    logic          ovf_s;
    logic          unf_s;
    logic          err_ovf_r;
    logic          err_unf_r;

    // Tally allocates and writebacks per register; r0 is never tracked.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            acnt_s[r] = {SW{1'b0}};
            wcnt_s[r] = {SW{1'b0}};
            for (int j = 0; j < NW; j++) begin
                if (alloc[j] && (alloc_addr[j*AW +: AW] != REG_ZERO) &&
                    (alloc_addr[j*AW +: AW] == AW'(r))) begin
                    acnt_s[r] = acnt_s[r] + CNT_ONE;
                end else begin
                    acnt_s[r] = acnt_s[r];
                end
                if (we[j] && (waddr[j*AW +: AW] != REG_ZERO) &&
                    (waddr[j*AW +: AW] == AW'(r))) begin
                    wcnt_s[r] = wcnt_s[r] + CNT_ONE;
                end else begin
                    wcnt_s[r] = wcnt_s[r];
                end
            end
        end
    end

    // Next counter values with saturation; a flush restarts from this cycle's allocates only.
    always_comb begin
        ovf_s  = 1'b0;
        unf_s  = 1'b0;
        sum_s  = {SW{1'b0}};
        diff_s = {SW{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            sum_s = (flush ? {SW{1'b0}} : {{(SW-CW){1'b0}}, cnt_r[r]}) + acnt_s[r];
            if (sum_s > CNT_MAX) begin
                ovf_s = 1'b1;
            end else begin
                ovf_s = ovf_s;
            end
            if (flush) begin
                diff_s       = sum_s;
                cnt_nxt_s[r] = (sum_s > CNT_MAX) ? {CW{1'b1}} : sum_s[CW-1:0];
            end else if (wcnt_s[r] > sum_s) begin
                unf_s        = 1'b1;
                diff_s       = {SW{1'b0}};
                cnt_nxt_s[r] = {CW{1'b0}};
            end else begin
                diff_s       = sum_s - wcnt_s[r];
                cnt_nxt_s[r] = (diff_s > CNT_MAX) ? {CW{1'b1}} : diff_s[CW-1:0];
            end
        end
    end

    // Counter and sticky error flag state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= {CW{1'b0}};
            end
            err_ovf_r <= 1'b0;
            err_unf_r <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
            err_ovf_r <= err_ovf_r | ovf_s;
            err_unf_r <= err_unf_r | unf_s;
        end
    end

    // Busy = writes still outstanding after this cycle's writebacks land.
    always_comb begin
        rbusy_s = {NR{1'b0}};
        for (int i = 0; i < NR; i++) begin
            if (rst && re[i] && (raddr[i*AW +: AW] != REG_ZERO) &&
                ({{(SW-CW){1'b0}}, cnt_r[raddr[i*AW +: AW]]} > wcnt_s[raddr[i*AW +: AW]])) begin
                rbusy_s[i] = 1'b1;
            end else begin
                rbusy_s[i] = 1'b0;
            end
        end
    end

    assign rbusy   = rbusy_s;
    assign err_ovf = err_ovf_r;
    assign err_unf = err_unf_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS GPR file for the dual-issue ID stage: NR bypassed read
// ports, NW writeback ports (highest port wins on conflict), and the
// pending-write scoreboard used for RAW hazard detection.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW   = RF_DW,
    parameter int NREG = RF_NREG,
    parameter int NR   = 4,
    parameter int NW   = 2,
    parameter int CW   = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    re,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic [NW-1:0]    alloc,
    input  logic [NW*AW-1:0] alloc_addr,
    input  logic             flush,
    output logic             err_ovf,
    output logic             err_unf
);

    logic [DW-1:0]    regs_r [NREG];
    logic [NR*DW-1:0] rdata_s;

    // Commit writebacks; a later port overrides an earlier one on the same register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= {DW{1'b0}};
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && (waddr[j*AW +: AW] != REG_ZERO)) begin
                    regs_r[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
                end
            end
        end
    end

    // Zero-latency reads with write-to-read bypass from the highest matching port.
    always_comb begin
        rdata_s = {(NR*DW){1'b0}};
        for (int i = 0; i < NR; i++) begin
            if (rst && re[i] && (raddr[i*AW +: AW] != REG_ZERO)) begin
                rdata_s[i*DW +: DW] = regs_r[raddr[i*AW +: AW]];
                for (int j = 0; j < NW; j++) begin
                    if (we[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
                        rdata_s[i*DW +: DW] = wdata[j*DW +: DW];
                    end else begin
                        rdata_s[i*DW +: DW] = rdata_s[i*DW +: DW];
                    end
                end
            end else begin
                rdata_s[i*DW +: DW] = {DW{1'b0}};
            end
        end
    end

    assign rdata = rdata_s;

    regfile_scoreboard #(
        .NREG (NREG),
        .NR   (NR),
        .NW   (NW),
        .CW   (CW),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .re         (re),
        .raddr      (raddr),
        .we         (we),
        .waddr      (waddr),
        .alloc      (alloc),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .rbusy      (rbusy),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected values are queued as each step is
// driven and popped/compared against the DUT outputs before the next edge.
module tb_regfile_mp;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int NR   = 4;
    localparam int NW   = 2;
    localparam int CW   = 2;
    localparam int AW   = 5;

    localparam int K_RD   = 0;
    localparam int K_BUSY = 1;
    localparam int K_OVF  = 2;
    localparam int K_UNF  = 3;

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW-1:0]    alloc;
    logic [NW*AW-1:0] alloc_addr;
    logic             flush;
    logic             err_ovf;
    logic             err_unf;

    exp_t sbq[$];
    int   n_assert;
    int   n_fail;

    regfile_mp #(
        .DW (DW), .NREG (NREG), .NR (NR), .NW (NW), .CW (CW), .AW (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .re         (re),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .alloc      (alloc),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_begin();
        @(negedge clk);
        re         = '0;
        raddr      = '0;
        we         = '0;
        waddr      = '0;
        wdata      = '0;
        alloc      = '0;
        alloc_addr = '0;
        flush      = 1'b0;
    endtask

    task automatic rd(input int p, input int a);
        re[p]              = 1'b1;
        raddr[p*AW +: AW]  = AW'(a);
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        we[p]              = 1'b1;
        waddr[p*AW +: AW]  = AW'(a);
        wdata[p*DW +: DW]  = d;
    endtask

    task automatic al(input int p, input int a);
        alloc[p]                = 1'b1;
        alloc_addr[p*AW +: AW]  = AW'(a);
    endtask

    task automatic want(input string tag, input int kind, input int port, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.port = port;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                K_RD:    obs = rdata[e.port*DW +: DW];
                K_BUSY:  obs = {31'd0, rbusy[e.port]};
                K_OVF:   obs = {31'd0, err_ovf};
                K_UNF:   obs = {31'd0, err_unf};
                default: obs = 32'hDEAD_BEEF;
            endcase
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        re         = '0;
        raddr      = '0;
        we         = '0;
        waddr      = '0;
        wdata      = '0;
        alloc      = '0;
        alloc_addr = '0;
        flush      = 1'b0;

        // reset held for two edges; outputs forced low meanwhile
        step_begin();
        for (int p = 0; p < NR; p++) begin
            rd(p, p + 1);
            want("rst_rdata", K_RD, p, 32'h0);
            want("rst_rbusy", K_BUSY, p, 32'h0);
        end
        check_all();
        step_begin();
        check_all();

        // released: everything cleared
        step_begin();
        rst = 1'b1;
        for (int p = 0; p < NR; p++) begin
            rd(p, p + 1);
            want("init_rdata", K_RD, p, 32'h0);
            want("init_rbusy", K_BUSY, p, 32'h0);
        end
        want("init_ovf", K_OVF, 0, 32'h0);
        want("init_unf", K_UNF, 0, 32'h0);
        check_all();

        // two allocates of r7 in one cycle
        step_begin();
        al(0, 7); al(1, 7);
        check_all();

        // alloc r5; same-cycle allocate not yet visible, r7 busy
        step_begin();
        al(0, 5); rd(0, 5); rd(1, 7);
        want("alloc_same_cycle", K_BUSY, 0, 32'h0);
        want("r7_busy", K_BUSY, 1, 32'h1);
        check_all();

        // bypass: write r5 and read it in the same cycle
        step_begin();
        wr(0, 5, 32'h1234); rd(0, 5);
        want("bypass_data", K_RD, 0, 32'h1234);
        want("bypass_busy", K_BUSY, 0, 32'h0);
        check_all();

        step_begin();
        rd(0, 5);
        want("stored_r5", K_RD, 0, 32'h1234);
        want("r5_idle", K_BUSY, 0, 32'h0);
        check_all();

        // both ports write r7; highest port wins in bypass and array
        step_begin();
        wr(0, 7, 32'hAAAA); wr(1, 7, 32'hBBBB); rd(0, 7);
        want("conflict_bypass", K_RD, 0, 32'hBBBB);
        want("conflict_busy", K_BUSY, 0, 32'h0);
        check_all();

        step_begin();
        wr(0, 0, 32'hFFFF); rd(0, 7); rd(1, 0); rd(2, 0);
        raddr[3*AW +: AW] = AW'(7);
        want("conflict_stored", K_RD, 0, 32'hBBBB);
        want("r0_bypass", K_RD, 1, 32'h0);
        want("r0_busy", K_BUSY, 2, 32'h0);
        want("re_off_data", K_RD, 3, 32'h0);
        want("no_unf_yet", K_UNF, 0, 32'h0);
        check_all();

        step_begin();
        rd(0, 0);
        want("r0_stored", K_RD, 0, 32'h0);
        want("no_ovf_yet", K_OVF, 0, 32'h0);
        check_all();

        // scoreboard on r9: two allocates, two writebacks
        step_begin();
        al(0, 9); rd(0, 9);
        want("r9_a1_same", K_BUSY, 0, 32'h0);
        check_all();
        step_begin();
        al(0, 9); rd(0, 9);
        want("r9_cnt1", K_BUSY, 0, 32'h1);
        check_all();
        step_begin();
        rd(0, 9);
        want("r9_cnt2", K_BUSY, 0, 32'h1);
        check_all();
        step_begin();
        wr(0, 9, 32'h0099); rd(0, 9);
        want("r9_wb1_busy", K_BUSY, 0, 32'h1);
        check_all();
        step_begin();
        wr(0, 9, 32'h009A); rd(0, 9);
        want("r9_wb2_release", K_BUSY, 0, 32'h0);
        want("r9_wb2_data", K_RD, 0, 32'h009A);
        check_all();
        step_begin();
        rd(0, 9);
        want("r9_done", K_BUSY, 0, 32'h0);
        want("r9_unf", K_UNF, 0, 32'h0);
        check_all();

        // flush: r2 pending 2, flush with alloc r6 and an unallocated writeback
        step_begin();
        al(0, 2); al(1, 2);
        check_all();
        step_begin();
        flush = 1'b1; al(0, 6); wr(0, 11, 32'h0B11); rd(0, 2);
        want("pre_flush_r2", K_BUSY, 0, 32'h1);
        check_all();
        step_begin();
        rd(0, 2); rd(1, 6); rd(2, 11);
        want("flush_r2", K_BUSY, 0, 32'h0);
        want("flush_r6", K_BUSY, 1, 32'h1);
        want("flush_wb_data", K_RD, 2, 32'h0B11);
        want("flush_no_unf", K_UNF, 0, 32'h0);
        check_all();

        // saturation: four allocates of r3
        for (int k = 0; k < 4; k++) begin
            step_begin();
            al(0, 3);
            check_all();
        end
        step_begin();
        wr(0, 3, 32'h0031); rd(0, 3);
        want("sat_ovf", K_OVF, 0, 32'h1);
        want("sat_wb1", K_BUSY, 0, 32'h1);
        check_all();
        step_begin();
        wr(0, 3, 32'h0032); rd(0, 3);
        want("sat_wb2", K_BUSY, 0, 32'h1);
        check_all();
        step_begin();
        wr(0, 3, 32'h0033); rd(0, 3);
        want("sat_wb3", K_BUSY, 0, 32'h0);
        check_all();

        // underflow: writeback to r4 with nothing outstanding
        step_begin();
        wr(0, 4, 32'h4444);
        want("pre_unf", K_UNF, 0, 32'h0);
        check_all();
        step_begin();
        rd(0, 4); rd(1, 3);
        want("unf_set", K_UNF, 0, 32'h1);
        want("unf_data", K_RD, 0, 32'h4444);
        want("r3_data", K_RD, 1, 32'h0033);
        want("ovf_sticky", K_OVF, 0, 32'h1);
        check_all();

        // reset mid-operation overrides write and allocate
        step_begin();
        rst = 1'b0;
        wr(0, 12, 32'h0C12); al(0, 13); rd(0, 4); rd(1, 6);
        want("midrst_rdata", K_RD, 0, 32'h0);
        want("midrst_rbusy", K_BUSY, 1, 32'h0);
        check_all();
        step_begin();
        rst = 1'b1;
        rd(0, 4); rd(1, 6); rd(2, 12); rd(3, 13);
        want("post_rst_r4", K_RD, 0, 32'h0);
        want("post_rst_r6", K_BUSY, 1, 32'h0);
        want("post_rst_r12", K_RD, 2, 32'h0);
        want("post_rst_r13", K_BUSY, 3, 32'h0);
        want("post_rst_ovf", K_OVF, 0, 32'h0);
        want("post_rst_unf", K_UNF, 0, 32'h0);
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Multi-port MIPS general-purpose register file with an integrated pending-write scoreboard, for the dual-issue ID stage.
- Generalises the single-write, dual-read register file:
  - NR read ports and NW write ports.
  - Write-to-read bypass on every port.
  - Per-register outstanding-write counters, so the issue logic can detect RAW hazards.
  - Flush support for mispredicts.
- Sits between the decoder/issue logic (reads, allocates) and the WB stage (writebacks).

Parameters:
- DW, 32, data width.
- NREG, 32, number of registers; AW = $clog2(NREG).
- NR, 4, read ports.
- NW, 2, write/writeback ports; also the number of allocate ports.
- CW, 2, pending-counter width; max outstanding writes per register = 2^CW-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- re  in  NR  per-port read enable.
- raddr  in  NR*AW  read addresses, packed; port i at [i*AW +: AW].
- rdata  out  NR*DW  read data, packed.
- rbusy  out  NR  1 = register still has an outstanding write after this cycle's writebacks.
- we  in  NW  writeback enable.
- waddr  in  NW*AW  writeback addresses.
- wdata  in  NW*DW  writeback data.
- alloc  in  NW  issue-side destination allocate.
- alloc_addr  in  NW*AW  allocated destination registers.
- flush  in  1  clears all pending counters.
- err_ovf  out  1  sticky: allocate attempted on a saturated counter.
- err_unf  out  1  sticky: writeback to a register whose counter is 0.

Behaviour:
- Reset (rst==0 at posedge):
  - All registers cleared to 0; all counters cleared to 0; err_ovf and err_unf cleared to 0.
  - While rst==0, rdata=0 and rbusy=0 combinationally.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and allocates to it are ignored and raise no error.
- Write:
  - At posedge when we[j]=1 and waddr[j]!=0, regs[waddr[j]] <= wdata[j].
  - Two ports writing the same address: the highest-index port wins.
- Read (combinational, zero latency):
  - re[i]==0 or raddr[i]==0 -> rdata[i]=0.
  - Otherwise, if any enabled write port targets raddr[i] this cycle, rdata[i] = wdata of the highest-index such port (bypass).
  - Otherwise rdata[i] = regs[raddr[i]].
- Counter update per register r at posedge:
  - next = cnt[r] + A - W.
  - A = number of alloc ports targeting r.
  - W = number of we ports targeting r. Duplicate writes to the same register in one cycle each count.
  - Result saturates to the range 0 .. 2^CW-1.
  - If cnt[r]+A exceeds the max, set err_ovf.
  - If W exceeds cnt[r]+A, set err_unf. The write data is still committed.
- rbusy[i] = (cnt[raddr[i]] - W(raddr[i])) > 0, using the current-cycle W.
  - Allocates in the same cycle do not affect rbusy; they become visible next cycle.
  - rbusy[i]=0 when re[i]==0.
- Flush (flush==1, rst==1):
  - All counters become A for the same-cycle allocates only; pre-flush pending writes are forgotten.
  - Writebacks in the flush cycle still write data.
  - No underflow error is raised in a flush cycle.
- Error flags are sticky until reset.
- Reset asserted mid-operation overrides flush, alloc and we in that cycle.

Decomposition:
- Package regfile_pkg: DW/AW defaults, reg_addr_t, reg_data_t, REG_ZERO constant.
- Sub-module regfile_scoreboard:
  - Holds the counters, rbusy generation and error flags.
  - Parametrised by NREG, NR, NW, CW.
- Top level holds the data array and bypass muxes.

Test Plan:
- Reset: rst=0 for 2 cycles, then read ports 1..4 -> rdata=0, rbusy=0, err flags 0.
- Bypass: we[0]=1, waddr=5, wdata=0x1234 with raddr[0]=5 in the same cycle -> rdata[0]=0x1234. Next cycle, no write -> rdata[0]=0x1234.
- Write conflict and r0:
  - Ports 0 and 1 both write register 7 with 0xAAAA/0xBBBB -> reg7=0xBBBB.
  - Write 0xFFFF to r0 -> reads of r0 return 0.
- Scoreboard:
  - alloc r9 twice over 2 cycles -> rbusy=1.
  - One writeback to r9 -> rbusy still 1.
  - Second writeback -> rbusy=0 in that same cycle (combinational release).
- Saturation: with CW=2, 4 allocates to r3 -> counter 3, err_ovf=1. Writeback to r4 with count 0 -> err_unf=1, data written.
- Flush: r2 pending 2; flush with same-cycle alloc r6 -> next cycle r2 not busy, r6 busy (count 1).
